// File: rtl/aes_stream_ctrl_if.sv
// Valid/ready stream bundle between the AES sequencer and its neighbours:
// 32-bit key/plaintext words in, 32-bit ciphertext beats out.
interface aes_stream_ctrl_if;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic        s_key;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic        m_last;

  modport master (
    output s_valid, s_data, s_key, m_ready,
    input  s_ready, m_valid, m_data, m_last
  );

  modport slave (
    input  s_valid, s_data, s_key, m_ready,
    output s_ready, m_valid, m_data, m_last
  );
endinterface

// File: rtl/aes_stream_ctrl.sv
// Sequencer around the AES128 core: packs streamed key/plaintext words,
// waits the core latency, then drains the ciphertext as four beats.
module aes_stream_ctrl #(
  parameter int LATENCY = 12
) (
  input  logic              clk,
  input  logic              reset,
  aes_stream_ctrl_if.slave  bus,
  output logic [31:0]       aes_data_0,
  output logic [31:0]       aes_data_1,
  output logic [31:0]       aes_data_2,
  output logic [31:0]       aes_data_3,
  output logic [31:0]       aes_key_0,
  output logic [31:0]       aes_key_1,
  output logic [31:0]       aes_key_2,
  output logic [31:0]       aes_key_3,
  input  logic [31:0]       aes_out_0,
  input  logic [31:0]       aes_out_1,
  input  logic [31:0]       aes_out_2,
  input  logic [31:0]       aes_out_3,
  output logic              busy
);

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {LOAD, WAIT, DRAIN} state_t;

  state_t            state;
  logic [1:0]        key_cnt;
  logic [1:0]        data_cnt;
  logic [1:0]        beat;
  logic [1:0]        beat_nxt;
  logic [7:0]        wait_cnt;
  logic [DATA_W-1:0] key_w  [4];
  logic [DATA_W-1:0] data_w [4];
  logic [DATA_W-1:0] obuf   [4];

  // Combinational so that a reset asserted while in LOAD closes the input at once.
  assign bus.s_ready = (state == LOAD) && !reset;
  assign beat_nxt    = beat + 2'd1;

  assign aes_key_0  = key_w[0];
  assign aes_key_1  = key_w[1];
  assign aes_key_2  = key_w[2];
  assign aes_key_3  = key_w[3];
  assign aes_data_0 = data_w[0];
  assign aes_data_1 = data_w[1];
  assign aes_data_2 = data_w[2];
  assign aes_data_3 = data_w[3];

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= LOAD;
      key_cnt     <= '0;
      data_cnt    <= '0;
      beat        <= '0;
      wait_cnt    <= '0;
      bus.m_valid <= 1'b0;
      bus.m_data  <= '0;
      bus.m_last  <= 1'b0;
      busy        <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        key_w[i]  <= '0;
        data_w[i] <= '0;
        obuf[i]   <= '0;
      end
    end else begin
      case (state)
        // Stream words land MS-word first, so counter value n targets word 3-n.
        LOAD: begin
          if (bus.s_valid && bus.s_ready) begin
            if (bus.s_key) begin
              key_w[~key_cnt] <= bus.s_data;
              key_cnt         <= key_cnt + 2'd1;
            end else begin
              data_w[~data_cnt] <= bus.s_data;
              data_cnt          <= data_cnt + 2'd1;
              if (data_cnt == 2'd3) begin
                wait_cnt <= 8'(LATENCY - 1);
                state    <= WAIT;
                busy     <= 1'b1;
              end
            end
          end
        end
        WAIT: begin
          if (wait_cnt == 8'd0) begin
            obuf[0]     <= aes_out_0;
            obuf[1]     <= aes_out_1;
            obuf[2]     <= aes_out_2;
            obuf[3]     <= aes_out_3;
            bus.m_valid <= 1'b1;
            bus.m_data  <= aes_out_3;
            bus.m_last  <= 1'b0;
            state       <= DRAIN;
          end else begin
            wait_cnt <= wait_cnt - 8'd1;
          end
        end
        DRAIN: begin
          if (bus.m_ready) begin
            if (beat == 2'd3) begin
              beat        <= '0;
              bus.m_valid <= 1'b0;
              bus.m_last  <= 1'b0;
              busy        <= 1'b0;
              state       <= LOAD;
            end else begin
              beat       <= beat_nxt;
              bus.m_data <= obuf[~beat_nxt];
              bus.m_last <= (beat_nxt == 2'd3);
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: doc/aes_stream_ctrl.md
Name: aes_stream_ctrl

Overview:
- Upstream/downstream sequencer for the AES128 encryption core.
- Accepts 32-bit key and plaintext words over a valid/ready stream and assembles them into the core's four key and four data input words.
- Holds those inputs stable for a fixed core latency, captures the core's four output words, and returns the ciphertext as four 32-bit beats over a valid/ready stream.

Parameters:
- LATENCY, 12, clock cycles from the launch edge to the edge at which the AES128 outputs are captured; legal range 1..255.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- s_valid  input  1  input word valid.
- s_ready  output  1  input word accepted when s_valid && s_ready.
- s_data  input  32  input word.
- s_key  input  1  1 = s_data is a key word; 0 = plaintext word.
- m_valid  output  1  ciphertext beat valid.
- m_ready  input  1  downstream accepts the beat.
- m_data  output  32  ciphertext beat.
- m_last  output  1  high on the 4th beat of a block.
- aes_data_0..aes_data_3  output  32 each  to AES128 inp_data_0..3.
- aes_key_0..aes_key_3  output  32 each  to AES128 inp_key_0..3.
- aes_out_0..aes_out_3  input  32 each  from AES128 out_data_0..3.
- busy  output  1  high in WAIT and DRAIN.

Behaviour:
- Word order:
  - The 128-bit key is {aes_key_3,aes_key_2,aes_key_1,aes_key_0}; data and output words follow the same packing.
  - All streams carry the most significant word first: beat 0 maps to word 3, beat 3 to word 0.
- Reset (synchronous, active-high):
  - state=LOAD; key_cnt=0; data_cnt=0; beat=0; wait counter=0.
  - All aes_key_* and aes_data_* = 0.
  - m_valid=0, m_data=0, m_last=0, busy=0.
  - s_ready=0 during any cycle in which reset is high; s_ready=1 in the first cycle after reset deasserts.
  - Reset mid-operation abandons any partial key, partial block, or undrained ciphertext.
- State LOAD:
  - s_ready=1.
  - Accepted key word: written to aes_key_(3-key_cnt); key_cnt increments and wraps 3->0.
  - Accepted data word: written to aes_data_(3-data_cnt); data_cnt increments.
  - Key and data words may be freely interleaved; each stream has its own counter.
  - The key register persists across blocks. A block launched before any key is loaded uses the current register contents (0 after reset).
  - A partially reloaded key (key_cnt != 0 at launch) is used as is, i.e. a mix of old and new words; the bench must not depend on this case.
  - The edge accepting the 4th data word is the launch edge: data_cnt->0, wait counter->LATENCY-1, state->WAIT.
- State WAIT:
  - s_ready=0 and busy=1; aes_key_* and aes_data_* are held stable.
  - The wait counter decrements each cycle.
  - On the edge where the counter is 0: aes_out_0..3 are captured into the output buffer, state->DRAIN, m_valid->1, m_data->captured word 3.
  - Net timing: m_valid rises exactly LATENCY+1 cycles after the launch handshake cycle.
- State DRAIN:
  - m_valid=1 and busy=1.
  - m_data = buffer word (3-beat); m_last = (beat==3).
  - m_data and m_last are held while m_ready=0 (backpressure of any length).
  - On m_valid && m_ready: beat increments. On the 4th beat: beat->0, m_valid->0, m_last->0, state->LOAD, so s_ready=1 in the next cycle.
- Throughput: the input stream is stalled in WAIT and DRAIN; blocks do not overlap.
- No arithmetic beyond counters; every counter wraps exactly as stated above.

Test Plan:
- FIPS-197 C.1:
  - Stimulus: key words 00010203, 04050607, 08090a0b, 0c0d0e0f, then data 00112233, 44556677, 8899aabb, ccddeeff, with m_ready=1.
  - Required: beats 69c4e0d8, 6a7b0430, d8cdb780, 70b4c55a; m_last on beat 4; m_valid rises exactly LATENCY+1 cycles after the 4th data handshake.
- Key persistence:
  - Stimulus: after the first test, send only data 00112233..ccddeeff again with no new key.
  - Required: identical ciphertext.
- Interleave:
  - Stimulus: FIPS-197 B vector. Order: key 2b7e1516, data 3243f6a8, key 28aed2a6, key abf71588, data 885a308d, key 09cf4f3c, data 313198a2, data e0370734.
  - Required: beats 3925841d, 02dc09fb, dc118597, 196a0b32.
- Backpressure:
  - Stimulus: hold m_ready=0 for 20 cycles in DRAIN, then toggle it every other cycle.
  - Required: m_data stays 3925841d until the first accept; s_ready=0 and busy=1 throughout; all four beats delivered in order.
- Stall in WAIT:
  - Stimulus: drive s_valid=1 with data words during WAIT.
  - Required: s_ready=0; no handshake occurs; aes_data_* unchanged.
- Reset mid-operation:
  - Stimulus: assert reset for 1 cycle during WAIT.
  - Required: next cycle state=LOAD, s_ready=1, m_valid=0, all aes_* outputs = 0; the following full block encrypts correctly.
